// File: rtl/hash_pkg.sv
// Shared opcodes, default multiplier and packed request layout for the hash request path.
package hash_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_LOOKUP = 2'b10;
    localparam logic [1:0] OP_DELETE = 2'b11;

    // Golden-ratio constant; odd so the multiply is a bijection on the key space.
    localparam logic [31:0] DEFAULT_HASH_MULT = 32'h9E37_79B1;

    localparam int unsigned REQ_KEY_WIDTH = 32;
    localparam int unsigned REQ_WIDTH     = REQ_KEY_WIDTH + 2;

    typedef struct packed {
        logic [1:0]               op;
        logic [REQ_KEY_WIDTH-1:0] key;
    } hash_req_t;

endpackage

// File: rtl/hash_mult_unit.sv
// Combinational multiply-shift hash: index is the top INDEX_WIDTH bits of key*mult mod 2^KEY_WIDTH.
module hash_mult_unit #(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH = 10,
    parameter logic [31:0] HASH_MULT   = 32'h9E37_79B1
) (
    input  logic [KEY_WIDTH-1:0]   key_i,
    output logic [INDEX_WIDTH-1:0] index_o
);

    localparam logic [KEY_WIDTH-1:0] Mult = KEY_WIDTH'(HASH_MULT);

    logic [KEY_WIDTH-1:0] prod;

    assign prod    = key_i * Mult;
    assign index_o = prod[KEY_WIDTH-1 -: INDEX_WIDTH];

    if (INDEX_WIDTH < KEY_WIDTH) begin : g_low_bits
        logic unused_low_prod;
        assign unused_low_prod = ^prod[KEY_WIDTH-INDEX_WIDTH-1:0];
    end

endmodule

// File: rtl/hash_req_dispatcher.sv
// Pops key requests from a show-ahead FIFO, drops NOPs, hashes keys and emits them via a 2-stage
// stallable pipeline. Define HASH_DISPATCH_STATS_EN to enable the saturating stat counters.
module hash_req_dispatcher
    import hash_pkg::*;
#(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH = 10,
    parameter logic [31:0] HASH_MULT   = DEFAULT_HASH_MULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [KEY_WIDTH+1:0]   fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_op,
    output logic [KEY_WIDTH-1:0]   out_key,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [31:0]            stat_req_count,
    output logic [31:0]            stat_nop_count
);

    logic                   s1_valid_q, s1_valid_d;
    logic [1:0]             s1_op_q, s1_op_d;
    logic [KEY_WIDTH-1:0]   s1_key_q, s1_key_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [1:0]             s2_op_q, s2_op_d;
    logic [KEY_WIDTH-1:0]   s2_key_q, s2_key_d;
    logic [INDEX_WIDTH-1:0] s2_index_q, s2_index_d;

    logic                   s1_adv, s2_adv;
    logic [1:0]             head_op;
    logic [INDEX_WIDTH-1:0] s1_index;

    assign head_op = fifo_data[KEY_WIDTH+1 -: 2];
    assign s2_adv  = !s2_valid_q || out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;

    assign fifo_rd_en = !reset && !fifo_empty && s1_adv;

    hash_mult_unit #(
        .KEY_WIDTH  (KEY_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH),
        .HASH_MULT  (HASH_MULT)
    ) u_hash (
        .key_i  (s1_key_q),
        .index_o(s1_index)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_key_d   = s1_key_q;
        s2_valid_d = s2_valid_q;
        s2_op_d    = s2_op_q;
        s2_key_d   = s2_key_q;
        s2_index_d = s2_index_q;

        // A popped NOP is loaded with valid low, so it never occupies a pipeline slot.
        if (s1_adv) begin
            s1_valid_d = fifo_rd_en && (head_op != OP_NOP);
            if (fifo_rd_en) begin
                s1_op_d  = head_op;
                s1_key_d = fifo_data[KEY_WIDTH-1:0];
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_op_d    = s1_op_q;
                s2_key_d   = s1_key_q;
                s2_index_d = s1_index;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_key_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_key_q   <= '0;
            s2_index_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_key_q   <= s1_key_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q    <= s2_op_d;
            s2_key_q   <= s2_key_d;
            s2_index_q <= s2_index_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_op    = s2_op_q;
    assign out_key   = s2_key_q;
    assign out_index = s2_index_q;

`ifdef HASH_DISPATCH_STATS_EN
    logic [31:0] req_cnt_q, req_cnt_d;
    logic [31:0] nop_cnt_q, nop_cnt_d;

    always_comb begin
        req_cnt_d = req_cnt_q;
        nop_cnt_d = nop_cnt_q;
        if (s2_valid_q && out_ready && (req_cnt_q != 32'hFFFF_FFFF)) begin
            req_cnt_d = req_cnt_q + 32'd1;
        end
        if (fifo_rd_en && (head_op == OP_NOP) && (nop_cnt_q != 32'hFFFF_FFFF)) begin
            nop_cnt_d = nop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_cnt_q <= '0;
            nop_cnt_q <= '0;
        end else begin
            req_cnt_q <= req_cnt_d;
            nop_cnt_q <= nop_cnt_d;
        end
    end

    assign stat_req_count = req_cnt_q;
    assign stat_nop_count = nop_cnt_q;
`else
    assign stat_req_count = '0;
    assign stat_nop_count = '0;
`endif

endmodule

// File: tb/tb_hash_req_dispatcher.sv
// Scoreboard bench for hash_req_dispatcher: a modelled show-ahead FIFO feeds the DUT,
// expected outputs are queued at stimulus time and checked by an independent monitor.
module tb_hash_req_dispatcher;
    import hash_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [33:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op;
    logic [31:0] out_key;
    logic [9:0]  out_index;
    logic [31:0] stat_req_count;
    logic [31:0] stat_nop_count;

    always #5 clk = ~clk;

    hash_req_dispatcher u_dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_key       (out_key),
        .out_index     (out_index),
        .stat_req_count(stat_req_count),
        .stat_nop_count(stat_nop_count)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int n_out  = 0;

    logic [33:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [43:0] exp_q [$];

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = fifo_mem[rd_ptr % 64];

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            rd_ptr <= rd_ptr + 1;
        end
        if (fifo_rd_en) pops <= pops + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] model_idx(input logic [31:0] k);
        logic [31:0] p;
        p = k * 32'h9E37_79B1;
        return p[31:22];
    endfunction

    // Push one FIFO entry; non-NOPs also queue their expected output.
    task automatic push(input logic [1:0] op, input logic [31:0] key, input logic [9:0] idx);
        hash_req_t r;
        r.op  = op;
        r.key = key;
        fifo_mem[wr_ptr % 64] = r;
        wr_ptr = wr_ptr + 1;
        if (op != OP_NOP) exp_q.push_back({op, key, idx});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 64'(n < budget), 64'd1);
    endtask

    always @(negedge clk) begin
        logic [43:0] e;
        if (!reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got op=%0h key=%0h idx=%0h expected none",
                         out_op, out_key, out_index);
            end else begin
                e = exp_q.pop_front();
                check("out_op", 64'(out_op), 64'(e[43:42]));
                check("out_key", 64'(out_key), 64'(e[41:10]));
                check("out_index", 64'(out_index), 64'(e[9:0]));
            end
        end
    end

    initial begin
        int base_pops, base_out, n, run;
        logic [31:0] base_req, base_nop;
        logic [43:0] snap;

        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        check("idle_stat_req", 64'(stat_req_count), 64'd0);
        check("idle_stat_nop", 64'(stat_nop_count), 64'd0);

        // Single LOOKUP, two-cycle latency from the pop edge
        push(OP_LOOKUP, 32'h0000_0001, 10'h278);
        #1;
        check("single_rd_en", 64'(fifo_rd_en), 64'd1);
        tick();
        check("single_valid_n", 64'(out_valid), 64'd0);
        tick();
        check("single_valid_n1", 64'(out_valid), 64'd1);
        drain("single", 20);

        // Streaming 16 INSERTs back-to-back
        for (int k = 0; k < 16; k++) push(OP_INSERT, 32'(k), model_idx(32'(k)));
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("stream_start_timeout", 64'(n < 10), 64'd1);
        run = 0;
        while (out_valid && run < 40) begin
            run++;
            tick();
        end
        check("stream_consecutive", 64'(run), 64'd16);
        drain("stream", 20);

        // Backpressure with 3 entries queued
        out_ready = 1'b0;
        base_pops = pops;
        push(OP_LOOKUP, 32'hDEAD_BEEF, model_idx(32'hDEAD_BEEF));
        push(OP_DELETE, 32'h1234_5678, model_idx(32'h1234_5678));
        push(OP_INSERT, 32'hFFFF_FFFF, model_idx(32'hFFFF_FFFF));
        tick();
        tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        snap = {out_op, out_key, out_index};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stable", 64'({out_valid, out_op, out_key, out_index}), 64'({1'b1, snap}));
        end
        check("bp_pops", 64'(pops - base_pops), 64'd2);
        out_ready = 1'b1;
        drain("bp", 20);
        check("bp_total_pops", 64'(pops - base_pops), 64'd3);

        // NOP filtering, hand-computed indices for keys 7 and 9
        base_pops = pops;
        base_out  = n_out;
        base_req  = stat_req_count;
        base_nop  = stat_nop_count;
        push(OP_NOP, 32'h0000_00AA, 10'h000);
        push(OP_DELETE, 32'd7, 10'h14E);
        push(OP_NOP, 32'h0000_00BB, 10'h000);
        push(OP_NOP, 32'h0000_00CC, 10'h000);
        push(OP_INSERT, 32'd9, 10'h23F);
        repeat (3) tick();
        drain("nop", 20);
        check("nop_pops", 64'(pops - base_pops), 64'd5);
        check("nop_outputs", 64'(n_out - base_out), 64'd2);
`ifdef HASH_DISPATCH_STATS_EN
        check("stat_nop", 64'(stat_nop_count - base_nop), 64'd3);
        check("stat_req", 64'(stat_req_count - base_req), 64'd2);
        check("stat_req_total", 64'(stat_req_count), 64'd22);
`else
        check("stat_nop_tied", 64'(stat_nop_count | base_nop), 64'd0);
        check("stat_req_tied", 64'(stat_req_count | base_req), 64'd0);
`endif

        // Reset while stalled with FIFO still non-empty
        out_ready = 1'b0;
        push(OP_LOOKUP, 32'h0000_0100, model_idx(32'h0000_0100));
        push(OP_LOOKUP, 32'h0000_0200, model_idx(32'h0000_0200));
        push(OP_LOOKUP, 32'h0000_0300, model_idx(32'h0000_0300));
        repeat (3) tick();
        check("rst_stall_valid", 64'(out_valid), 64'd1);
        check("rst_stall_fifo_nonempty", 64'(fifo_empty), 64'd0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_rd_en_gated", 64'(fifo_rd_en), 64'd0);
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'({out_op, out_key, out_index}), 64'd0);
        check("rst_stat_req", 64'(stat_req_count), 64'd0);
        check("rst_stat_nop", 64'(stat_nop_count), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
